// File: rtl/dmr_checker_pkg.sv
// State encoding and default sizing for the dual-core lockstep OBI checker.
package dmr_checker_pkg;

    localparam int unsigned DMR_CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DRAIN,
        ERROR
    } dmr_state_e;

endpackage

// File: rtl/obi_pkg.sv
// OBI request/response bundles shared by the lockstep checker and its environment.
package obi_pkg;

    typedef struct packed {
        logic        req;
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } obi_req_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
    } obi_resp_t;

endpackage

// File: rtl/dmr_obi_cmp.sv
// Combinational comparison of the two lockstep requests; flags any divergence.
module dmr_obi_cmp
    import obi_pkg::*;
#(
    parameter bit CMP_WDATA = 1'b1
) (
    input  obi_req_t a_i,
    input  obi_req_t b_i,
    output logic     mismatch_o
);

    always_comb begin
        mismatch_o = (a_i.req != b_i.req);
        if (a_i.req && b_i.req) begin
            if ((a_i.addr != b_i.addr) || (a_i.we != b_i.we) || (a_i.be != b_i.be))
                mismatch_o = 1'b1;
            // wdata only matters on writes; reads carry stale bus values
            if (CMP_WDATA && a_i.we && (a_i.wdata != b_i.wdata))
                mismatch_o = 1'b1;
        end
    end

endmodule

// File: rtl/ext_dmr_obi_checker.sv
// Merges two lockstep OBI request ports into one bus port and traps divergence.
// Optional mismatch counter enabled by defining DMR_CHECKER_MISMATCH_CNT_EN.
module ext_dmr_obi_checker
    import obi_pkg::*;
    import dmr_checker_pkg::*;
#(
    parameter int unsigned CNT_W     = DMR_CNT_W,
    parameter bit          CMP_WDATA = 1'b1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  obi_req_t  [1:0]      core_req_i,
    output obi_resp_t [1:0]      core_resp_o,
    output obi_req_t             bus_req_o,
    input  obi_resp_t            bus_resp_i,
    input  logic                 clear_i,
    output logic                 error_o,
    output logic [1:0]           dbg_req_o,
    output logic [CNT_W-1:0]     mismatch_cnt_o
);

    dmr_state_e state_q, state_d;
    logic       error_q, error_d;
    logic       dbg_q, dbg_d;
    logic       mismatch;
    obi_resp_t  resp;

    dmr_obi_cmp #(
        .CMP_WDATA (CMP_WDATA)
    ) u_cmp (
        .a_i        (core_req_i[0]),
        .b_i        (core_req_i[1]),
        .mismatch_o (mismatch)
    );

    always_comb begin
        state_d       = state_q;
        error_d       = error_q;
        bus_req_o     = core_req_i[0];
        bus_req_o.req = 1'b0;
        resp          = '0;
        resp.rdata    = bus_resp_i.rdata;

        case (state_q)
            IDLE: begin
                if (mismatch) begin
                    state_d = ERROR;
                end else begin
                    bus_req_o.req = core_req_i[0].req & core_req_i[1].req;
                    resp.gnt      = bus_resp_i.gnt;
                    if (bus_req_o.req && bus_resp_i.gnt)
                        state_d = WAIT;
                end
            end
            WAIT: begin
                resp.rvalid = bus_resp_i.rvalid;
                if (mismatch)
                    state_d = bus_resp_i.rvalid ? ERROR : DRAIN;
                else if (bus_resp_i.rvalid)
                    state_d = IDLE;
            end
            DRAIN: begin
                resp.rvalid = bus_resp_i.rvalid;
                if (bus_resp_i.rvalid)
                    state_d = ERROR;
            end
            ERROR: begin
                if (clear_i && !mismatch) begin
                    state_d = IDLE;
                    error_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        if (mismatch)
            error_d = 1'b1;

        // one debug pulse per fault episode, not on DRAIN->ERROR
        dbg_d = ((state_q == IDLE) || (state_q == WAIT)) &&
                ((state_d == DRAIN) || (state_d == ERROR));

        if (rst_i) begin
            bus_req_o.req = 1'b0;
            resp.gnt      = 1'b0;
            resp.rvalid   = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            error_q <= 1'b0;
            dbg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            error_q <= error_d;
            dbg_q   <= dbg_d;
        end
    end

    assign core_resp_o[0] = resp;
    assign core_resp_o[1] = resp;
    assign error_o        = error_q;
    assign dbg_req_o      = {dbg_q, dbg_q};

`ifdef DMR_CHECKER_MISMATCH_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (mismatch && (cnt_q != {CNT_W{1'b1}}))
            cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign mismatch_cnt_o = cnt_q;
`else
    assign mismatch_cnt_o = '0;
`endif

endmodule

// File: tb/tb_ext_dmr_obi_checker.sv
// Directed self-checking bench for ext_dmr_obi_checker (wdata-compare and no-wdata instances).
module tb_ext_dmr_obi_checker;
    import obi_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst, clear;
    obi_req_t  [1:0]  creq, creq_nw;
    obi_resp_t [1:0]  cresp, cresp_nw;
    obi_req_t         breq, breq_nw;
    obi_resp_t        bresp, bresp_nw;
    logic             err, err_nw;
    logic [1:0]       dbg, dbg_nw;
    logic [7:0]       cnt, cnt_nw;

    int checks = 0;
    int failures = 0;
    int exp_cnt = 0;

    ext_dmr_obi_checker #(.CNT_W(8), .CMP_WDATA(1'b1)) dut (
        .clk_i(clk), .rst_i(rst), .core_req_i(creq), .core_resp_o(cresp),
        .bus_req_o(breq), .bus_resp_i(bresp), .clear_i(clear),
        .error_o(err), .dbg_req_o(dbg), .mismatch_cnt_o(cnt)
    );

    ext_dmr_obi_checker #(.CNT_W(8), .CMP_WDATA(1'b0)) dut_nw (
        .clk_i(clk), .rst_i(rst), .core_req_i(creq_nw), .core_resp_o(cresp_nw),
        .bus_req_o(breq_nw), .bus_resp_i(bresp_nw), .clear_i(clear),
        .error_o(err_nw), .dbg_req_o(dbg_nw), .mismatch_cnt_o(cnt_nw)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic obi_req_t mk(input logic r, input logic [31:0] a, input logic we,
                                    input logic [3:0] be, input logic [31:0] wd);
        obi_req_t q;
        q.req = r; q.addr = a; q.we = we; q.be = be; q.wdata = wd;
        return q;
    endfunction

    function automatic int cexp();
`ifdef DMR_CHECKER_MISMATCH_CNT_EN
        return (exp_cnt > 255) ? 255 : exp_cnt;
`else
        return 0;
`endif
    endfunction

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic settle();
        #1;
    endtask

    obi_req_t rd;

    initial begin
        rd = mk(1'b1, 32'h2000_0100, 1'b0, 4'hF, 32'h0);
        rst = 1'b1; clear = 1'b0;
        creq = '0; creq_nw = '0; bresp = '0; bresp_nw = '0;

        // reset: outputs held quiet even with live traffic
        tick();
        creq[0] = rd; creq[1] = rd;
        bresp.gnt = 1'b1; bresp.rvalid = 1'b1;
        settle();
        check("rst_busreq", breq.req, 0);
        check("rst_gnt", cresp[0].gnt, 0);
        check("rst_rvalid", cresp[1].rvalid, 0);
        tick();
        rst = 1'b0; creq = '0; bresp = '0;
        tick();
        check("rst_err", err, 0);
        check("rst_dbg", dbg, 0);
        check("rst_cnt", cnt, 0);

        // matched read, gnt same cycle, rvalid two cycles later
        creq[0] = rd; creq[1] = rd; bresp.gnt = 1'b1;
        settle();
        check("rd_busreq", breq.req, 1);
        check("rd_addr", breq.addr, 32'h2000_0100);
        check("rd_be", breq.be, 4'hF);
        check("rd_gnt0", cresp[0].gnt, 1);
        check("rd_gnt1", cresp[1].gnt, 1);
        tick();
        bresp.gnt = 1'b0;
        settle();
        check("rd_wait_busreq", breq.req, 0);
        check("rd_wait_gnt", cresp[0].gnt, 0);
        tick();
        creq = '0;
        bresp.rvalid = 1'b1; bresp.rdata = 32'hDEAD_BEEF;
        settle();
        check("rd_rvalid0", cresp[0].rvalid, 1);
        check("rd_rvalid1", cresp[1].rvalid, 1);
        check("rd_rdata0", cresp[0].rdata, 32'hDEAD_BEEF);
        check("rd_rdata1", cresp[1].rdata, 32'hDEAD_BEEF);
        tick();
        bresp = '0;
        check("rd_err", err, 0);

        // write wdata mismatch in IDLE
        creq[0] = mk(1'b1, 32'h2000_0200, 1'b1, 4'hF, 32'h11);
        creq[1] = mk(1'b1, 32'h2000_0200, 1'b1, 4'hF, 32'h12);
        bresp.gnt = 1'b1;
        settle();
        check("wr_mm_busreq", breq.req, 0);
        check("wr_mm_gnt", cresp[0].gnt, 0);
        tick(); exp_cnt++;
        creq = '0; bresp = '0;
        check("wr_mm_err", err, 1);
        check("wr_mm_dbg", dbg, 2'b11);
        check("wr_mm_cnt", cnt, cexp());
        tick();
        check("wr_mm_dbg_off", dbg, 0);
        check("wr_mm_err_hold", err, 1);

        // ERROR: late rvalid discarded, no bus requests
        bresp.rvalid = 1'b1;
        creq[0] = rd; creq[1] = rd;
        settle();
        check("err_rvalid_drop", cresp[0].rvalid, 0);
        check("err_busreq", breq.req, 0);
        creq = '0; bresp = '0;

        // clear returns to IDLE
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clr_err", err, 0);
        creq[0] = rd; creq[1] = rd;
        settle();
        check("clr_idle_busreq", breq.req, 1);
        creq = '0;

        // clear coincident with a mismatch keeps the error
        creq[0] = rd;
        tick(); exp_cnt++;
        check("clrmm_enter_err", err, 1);
        clear = 1'b1;
        tick(); exp_cnt++;
        check("clrmm_err", err, 1);
        check("clrmm_dbg", dbg, 0);
        check("clrmm_cnt", cnt, cexp());
        creq = '0;
        tick();
        clear = 1'b0;
        check("clrmm_clear_after", err, 0);

        // mismatch during WAIT -> DRAIN, response still forwarded
        creq[0] = rd; creq[1] = rd; bresp.gnt = 1'b1;
        tick();
        bresp.gnt = 1'b0;
        creq[1].be = 4'h3;
        tick(); exp_cnt++;
        check("drain_err", err, 1);
        check("drain_dbg", dbg, 2'b11);
        creq = '0; clear = 1'b1;
        tick();
        clear = 1'b0;
        check("drain_clr_ignored", err, 1);
        check("drain_dbg_off", dbg, 0);
        bresp.rvalid = 1'b1; bresp.rdata = 32'h1234_5678;
        settle();
        check("drain_rvalid", cresp[0].rvalid, 1);
        check("drain_rdata", cresp[1].rdata, 32'h1234_5678);
        tick();
        settle();
        check("drain_to_err_drop", cresp[0].rvalid, 0);
        check("drain_to_err_dbg", dbg, 0);
        bresp = '0; clear = 1'b1;
        tick();
        clear = 1'b0;
        check("drain_clear", err, 0);

        // rvalid and mismatch in the same WAIT cycle
        creq[0] = rd; creq[1] = rd; bresp.gnt = 1'b1;
        tick();
        bresp.gnt = 1'b0;
        creq[1].addr = 32'h2000_0104;
        bresp.rvalid = 1'b1; bresp.rdata = 32'hCAFE_F00D;
        settle();
        check("wrv_rvalid", cresp[0].rvalid, 1);
        check("wrv_rdata", cresp[0].rdata, 32'hCAFE_F00D);
        tick(); exp_cnt++;
        creq = '0;
        settle();
        check("wrv_err", err, 1);
        check("wrv_dbg", dbg, 2'b11);
        check("wrv_in_error", cresp[0].rvalid, 0);
        bresp = '0; clear = 1'b1;
        tick();
        clear = 1'b0;
        check("wrv_clear", err, 0);

        // CMP_WDATA=0 ignores a wdata-only difference
        creq_nw[0] = mk(1'b1, 32'h2000_0300, 1'b1, 4'hF, 32'hAA);
        creq_nw[1] = mk(1'b1, 32'h2000_0300, 1'b1, 4'hF, 32'hBB);
        bresp_nw.gnt = 1'b1;
        settle();
        check("nw_busreq", breq_nw.req, 1);
        check("nw_wdata", breq_nw.wdata, 32'hAA);
        check("nw_gnt", cresp_nw[1].gnt, 1);
        tick();
        creq_nw = '0; bresp_nw.gnt = 1'b0; bresp_nw.rvalid = 1'b1;
        settle();
        check("nw_rvalid", cresp_nw[0].rvalid, 1);
        tick();
        bresp_nw = '0;
        check("nw_err", err_nw, 0);
        check("nw_cnt", cnt_nw, 0);

        // 300 consecutive mismatch cycles saturate the counter
        creq[0] = rd;
        for (int i = 0; i < 300; i++) tick();
        exp_cnt += 300;
        creq = '0;
        check("sat_cnt", cnt, cexp());
        check("sat_err", err, 1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("sat_clear_err", err, 0);
        check("sat_cnt_kept", cnt, cexp());

        // reset in WAIT drops the transaction; late rvalid discarded
        creq[0] = rd; creq[1] = rd; bresp.gnt = 1'b1;
        tick();
        creq = '0; bresp.gnt = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0; exp_cnt = 0;
        bresp.rvalid = 1'b1; bresp.rdata = 32'h5555_AAAA;
        settle();
        check("rstw_rvalid", cresp[0].rvalid, 0);
        check("rstw_cnt", cnt, 0);
        check("rstw_err", err, 0);
        creq[0] = rd; creq[1] = rd;
        settle();
        check("rstw_idle", breq.req, 1);
        creq = '0; bresp = '0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
